osd_event_sample_buffer: RTL
============================

Name: osd_event_sample_buffer

Overview:
- Capture stage directly upstream of the fixed-width event packetizer.
- Accepts one trace sample per cycle from the monitored core and queues it in a small FIFO.
- Presents queued samples on the packetizer's event_available/event_consumed/overflow/data handshake.
- When the FIFO cannot accept samples, counts the lost samples and inserts one overflow record carrying that count, in order.

Parameters:
- WIDTH, 32, sample width in bits; must be >= 16.
- DEPTH, 4, FIFO entries including overflow records; power of 2, >= 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- sample_data  in  WIDTH  sample payload.
- sample_valid  in  1  sample present this cycle; no backpressure, sample must be taken or counted.
- data  out  WIDTH  head entry payload; to packetizer data.
- overflow  out  1  head entry is an overflow record; to packetizer overflow.
- event_available  out  1  FIFO non-empty.
- event_consumed  in  1  packetizer finished the head entry; pop.

Behaviour:
- Reset (rst low, async):
  - FIFO empty, count=0, drop counter ov_cnt=0.
  - event_available=0, overflow=0, data=0.
  - A reset mid-operation discards all entries and the pending count.
- Storage:
  - Each entry holds {is_ovf, payload[WIDTH-1:0]}.
  - All outputs are driven from registered FIFO state; there is no same-cycle fall-through.
  - A sample pushed in cycle N is visible on the outputs in cycle N+1.
- Pop:
  - pop = event_consumed && event_available.
  - event_consumed while empty is ignored.
- Space: has_space = (count < DEPTH) || pop. A full FIFO accepts a push in the same cycle as a pop.
- Single write per cycle, with this priority:
  1. ov_cnt != 0 && has_space: write overflow record.
     - payload[15:0] = sat16(ov_cnt + sample_valid); payload[WIDTH-1:16] = 0.
     - ov_cnt <= 0.
     - A concurrent sample is folded into the record count, not stored.
  2. ov_cnt == 0 && sample_valid && has_space: write {0, sample_data}.
  3. sample_valid && !has_space: ov_cnt <= sat16(ov_cnt + 1).
  - Samples are never stored while ov_cnt != 0, which preserves ordering: the overflow record precedes any later sample.
- Counter arithmetic: sat16 clamps at 16'hFFFF and never wraps.
- Count update: count <= count + push - pop; count is always in 0..DEPTH.
- Pointers are log2(DEPTH) bits and wrap naturally.
- Outputs:
  - event_available = (count != 0).
  - overflow = head.is_ovf when non-empty, else 0.
  - data = head payload when non-empty, else 0.
- Outputs are stable while event_available=1 and no pop occurs; the packetizer may read data across many cycles.

Test Plan:
- Reset, then 3 samples 0xA1,0xA2,0xA3 on consecutive cycles, consumer idle:
  - event_available rises the cycle after 0xA1.
  - Popping yields 0xA1,0xA2,0xA3 in order, overflow=0.
  - After the third pop, event_available=0 and data=0.
- DEPTH=4, consumer idle, 7 consecutive samples:
  - First 4 are stored; ov_cnt=3.
  - One pop, with no sample that cycle, writes overflow record data[15:0]=3, overflow=1, behind the remaining 3 samples.
- Full FIFO, sample_valid and event_consumed asserted in the same cycle: sample stored, ov_cnt remains 0, count stays 4.
- ov_cnt=5 pending, free slot appears in the same cycle as a new sample: record data[15:0]=6, ov_cnt becomes 0. The next sample is stored normally.
- Consumer stalled for 70000 sample cycles while full, then one pop: record data[15:0]=0xFFFF (saturated), upper bits 0.
- rst driven low asynchronously mid-stream with 2 entries and ov_cnt=4: event_available, overflow, data go to 0 immediately. After release, the first new sample is delivered with overflow=0 and no stale record.

Source files
------------

// File: rtl/osd_event_sample_buffer.sv
// osd_event_sample_buffer
//   Capture stage in front of the event packetizer. Takes one trace sample per
//   cycle (no backpressure) into a small FIFO. When the FIFO is full, lost
//   samples are counted. The count is inserted in order as one overflow record
//   as soon as a slot frees up.
//
// Ports:
//   clk             clock
//   rst             asynchronous, active-low reset
//   sample_data     sample payload (WIDTH bits)
//   sample_valid    sample present this cycle
//   data            head entry payload (0 when empty)
//   overflow        head entry is an overflow record (0 when empty)
//   event_available FIFO non-empty
//   event_consumed  packetizer finished the head entry; pops it
module osd_event_sample_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sample_data,
    input  logic             sample_valid,
    output logic [WIDTH-1:0] data,
    output logic             overflow,
    output logic             event_available,
    input  logic             event_consumed
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Entry layout: {is_ovf, payload}
    logic [WIDTH:0]  mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [15:0]     ov_cnt_q, ov_cnt_d;

    logic            pop;
    logic            push;
    logic            has_space;
    logic [WIDTH:0]  wr_entry;
    logic [WIDTH:0]  head;
    logic [16:0]     ov_sum;
    logic [15:0]     ov_sat;

    assign pop       = event_consumed && (count_q != '0);
    assign has_space = (count_q < CW'(DEPTH)) || pop;

    // Drop count plus this cycle's sample. The same saturating sum serves two
    // cases: it folds a sample into a record, and it counts a dropped sample.
    assign ov_sum = {1'b0, ov_cnt_q} + 17'(sample_valid);
    assign ov_sat = ov_sum[16] ? 16'hFFFF : ov_sum[15:0];

    always_comb begin
        push     = 1'b0;
        wr_entry = '0;
        ov_cnt_d = ov_cnt_q;
        if (ov_cnt_q != 16'd0 && has_space) begin
            // A pending drop count goes out before any newer sample. This
            // keeps the record ahead of later data.
            push            = 1'b1;
            wr_entry[WIDTH] = 1'b1;
            wr_entry[15:0]  = ov_sat;
            ov_cnt_d        = 16'd0;
        end else if (ov_cnt_q == 16'd0 && sample_valid && has_space) begin
            push     = 1'b1;
            wr_entry = {1'b0, sample_data};
        end else if (sample_valid && !has_space) begin
            ov_cnt_d = ov_sat;
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ov_cnt_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ov_cnt_q <= ov_cnt_d;
        end
    end

    // Storage needs no reset. The outputs are masked by count, so stale
    // contents are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    // The outputs depend only on registered state. A write becomes visible
    // one cycle later, and the head holds steady until it is popped.
    assign head            = mem_q[rd_ptr_q];
    assign event_available = (count_q != '0);
    assign overflow        = event_available ? head[WIDTH] : 1'b0;
    assign data            = event_available ? head[WIDTH-1:0] : '0;

endmodule
